// File: rtl/vector_player.sv
// Vector memory player: streams stored stimulus vectors in one-shot or loop
// mode and compresses the returned responses into a MISR signature.
//
//   state | meaning
//   IDLE  | accepts memory loads and start
//   RUN   | issues one vector per cycle from mem[idx]
//   DONE  | single-cycle done pulse, then back to IDLE
module vector_player #(
   parameter int               WIDTH = 62,
   parameter int               DEPTH = 16,
   parameter logic [WIDTH-1:0] POLY  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_valid,
   input  logic [$clog2(DEPTH)-1:0]   ld_addr,
   input  logic [WIDTH-1:0]           ld_data,
   output logic                       ld_ready,
   input  logic                       start,
   input  logic                       mode,
   input  logic [$clog2(DEPTH):0]     num_vec,
   input  logic                       stop,
   output logic [WIDTH-1:0]           vec_out,
   output logic                       vec_valid,
   input  logic [WIDTH-1:0]           resp_in,
   output logic                       busy,
   output logic                       done,
   output logic [15:0]                pass_cnt,
   output logic [WIDTH-1:0]           sig_out
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [AW:0]      nv_q, nv_d;
   logic             mode_q, mode_d;
   logic [15:0]      pass_q, pass_d;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic [WIDTH-1:0] vec_q, vec_d;
   logic             valid_q, valid_d;
   logic             nv_ok;
   logic             last_idx;

   // Vector storage is deliberately left out of reset so patterns survive it.
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst && ld_valid && (state_q == S_IDLE) && ({1'b0, ld_addr} < DEPTH_W)) begin
         mem_q[ld_addr] <= ld_data;
      end
   end

   assign nv_ok    = (num_vec != '0) && (num_vec <= DEPTH_W);
   assign last_idx = ({1'b0, idx_q} == (nv_q - 1'b1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      nv_d    = nv_q;
      mode_d  = mode_q;
      pass_d  = pass_q;
      vec_d   = vec_q;
      valid_d = 1'b0;
      sig_d   = sig_q;

      // Signature absorbs the response belonging to the vector on vec_out now.
      if (valid_q) begin
         sig_d = ({sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0)) ^ resp_in;
      end

      case (state_q)
         S_IDLE: begin
            if (start && nv_ok) begin
               state_d = S_RUN;
               idx_d   = '0;
               pass_d  = '0;
               sig_d   = '0;
               mode_d  = mode;
               nv_d    = num_vec;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_DONE;
            end else begin
               vec_d   = mem_q[idx_q];
               valid_d = 1'b1;
               if (last_idx) begin
                  idx_d  = '0;
                  pass_d = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;
                  if (!mode_q) begin
                     state_d = S_DONE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         nv_q    <= '0;
         mode_q  <= 1'b0;
         pass_q  <= '0;
         sig_q   <= '0;
         vec_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         nv_q    <= nv_d;
         mode_q  <= mode_d;
         pass_q  <= pass_d;
         sig_q   <= sig_d;
         vec_q   <= vec_d;
         valid_q <= valid_d;
      end
   end

   assign ld_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign vec_out   = vec_q;
   assign vec_valid = valid_q;
   assign pass_cnt  = pass_q;
   assign sig_out   = sig_q;

endmodule

// File: tb/tb_vector_player.sv
// Randomized bench for vector_player: expected vector stream, pass count and
// signature come from a plain model of the player's playback rules.
module tb_vector_player;

   localparam int WIDTH = 62;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             ld_valid;
   logic [AW-1:0]    ld_addr;
   logic [WIDTH-1:0] ld_data;
   logic             ld_ready;
   logic             start;
   logic             mode;
   logic [AW:0]      num_vec;
   logic             stop;
   logic [WIDTH-1:0] vec_out;
   logic             vec_valid;
   logic [WIDTH-1:0] resp_in;
   logic             busy;
   logic             done;
   logic [15:0]      pass_cnt;
   logic [WIDTH-1:0] sig_out;

   always #5 clk = ~clk;

   vector_player #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .start     (start),
      .mode      (mode),
      .num_vec   (num_vec),
      .stop      (stop),
      .vec_out   (vec_out),
      .vec_valid (vec_valid),
      .resp_in   (resp_in),
      .busy      (busy),
      .done      (done),
      .pass_cnt  (pass_cnt),
      .sig_out   (sig_out)
   );

   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] mem_m [DEPTH];
   logic [WIDTH-1:0] sig_m;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] rnd_word();
      logic [63:0] w;
      w = {$urandom(), $urandom()};
      return w[WIDTH-1:0];
   endfunction

   // Signature as a polynomial division step with the default x^0 feedback.
   function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r);
      logic [WIDTH-1:0] fb;
      fb = s[WIDTH-1] ? WIDTH'(1) : '0;
      return (s << 1) ^ fb ^ r;
   endfunction

   task automatic load(input int a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      chk("ld_ready_idle", ld_ready, 1);
      ld_valid = 1'b1;
      ld_addr  = AW'(a);
      ld_data  = d;
      mem_m[a] = d;
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   // resp_mode: 0 random, 1 all zero, 2 single one on the first valid cycle.
   task automatic run(input logic md, input int nv, input int stop_after,
                      input int resp_mode, input bit poke_ld);
      int exp_issues;
      int k;
      int dones;
      bit after_done;
      logic [WIDTH-1:0] r;
      if (md) exp_issues = stop_after;
      else    exp_issues = (stop_after > 0 && stop_after < nv) ? stop_after : nv;
      k = 0;
      dones = 0;
      after_done = 1'b0;
      @(negedge clk);
      start   = 1'b1;
      mode    = md;
      num_vec = (AW+1)'(nv);
      resp_in = rnd_word();
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("valid_latency", vec_valid, 0);
      resp_in = rnd_word();
      sig_m = '0;
      @(negedge clk);
      for (int cyc = 0; cyc < exp_issues + 8; cyc++) begin
         stop = 1'b0;
         if (vec_valid) begin
            chk("vec_out", vec_out, mem_m[k % nv]);
            k++;
            if (resp_mode == 0)      r = rnd_word();
            else if (resp_mode == 1) r = '0;
            else                     r = (k == 1) ? WIDTH'(1) : '0;
            resp_in = r;
            sig_m = misr_step(sig_m, r);
            if (stop_after > 0 && k == stop_after) stop = 1'b1;
         end else begin
            resp_in = rnd_word();
            if (k > 0) chk("vec_hold", vec_out, mem_m[(k - 1) % nv]);
         end
         if (after_done) begin
            chk("start_in_done_ignored", busy, 0);
            start = 1'b0;
            after_done = 1'b0;
         end
         if (done) begin
            dones++;
            start = 1'b1;
            after_done = 1'b1;
         end
         if (poke_ld && busy) begin
            chk("ld_ready_run", ld_ready, 0);
            ld_valid = 1'b1;
            ld_addr  = AW'($urandom_range(0, DEPTH - 1));
            ld_data  = rnd_word();
         end else begin
            ld_valid = 1'b0;
         end
         @(negedge clk);
      end
      stop = 1'b0;
      start = 1'b0;
      ld_valid = 1'b0;
      chk("issues", k, exp_issues);
      chk("done_pulses", dones, 1);
      chk("pass_cnt", pass_cnt, exp_issues / nv);
      chk("sig_out", sig_out, sig_m);
      chk("busy_end", busy, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, vec_valid, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass_cnt, 0);
      chk({tag, "_sig"}, sig_out, 0);
      chk({tag, "_vec"}, vec_out, 0);
      chk({tag, "_ld_ready"}, ld_ready, 1);
   endtask

   initial begin
      int md, nv, sa;
      rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      start = 1'b0; mode = 1'b0; num_vec = '0; stop = 1'b0; resp_in = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 4; i++) load(i, WIDTH'(i + 1));
      run(1'b0, 4, 0, 0, 1'b0);
      run(1'b1, 3, 7, 0, 1'b0);
      run(1'b0, 4, 0, 1, 1'b0);
      chk("sig_all_zero", sig_out, 0);
      run(1'b0, 4, 0, 2, 1'b0);
      chk("sig_impulse", sig_out, 64'd8);

      // Out-of-range vector counts must leave the player idle.
      @(negedge clk);
      start = 1'b1; num_vec = 5'd0;
      @(negedge clk);
      num_vec = 5'(DEPTH + 1);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bad_start_busy", busy, 0);
         chk("bad_start_valid", vec_valid, 0);
         chk("bad_start_done", done, 0);
         @(negedge clk);
      end

      for (int i = 0; i < DEPTH; i++) load(i, rnd_word());
      run(1'b0, DEPTH, 0, 0, 1'b1);
      run(1'b1, 5, 12, 0, 1'b0);

      // Reset on the second RUN cycle.
      @(negedge clk);
      start = 1'b1; mode = 1'b1; num_vec = 5'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("mid_run_reset");
      @(negedge clk);
      chk("no_done_after_reset", done, 0);
      run(1'b0, 4, 0, 0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         md = int'($urandom_range(0, 1));
         nv = int'($urandom_range(1, DEPTH));
         if (md == 1) sa = int'($urandom_range(1, 40));
         else         sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, nv)) : 0;
         run(md[0], nv, sa, 0, $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_player.md
VECTOR_PLAYER -- requirements
Module: vector_player

Interface
REQ-001 Parameter: WIDTH, default 62, vector width in bits (stimulus and response).
REQ-002 Parameter: DEPTH, default 16, number of vector memory entries; AW = clog2(DEPTH).
REQ-003 Parameter: POLY, default WIDTH'h1 (bit0 set), MISR feedback polynomial.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ld_valid  input  1  memory write request.
REQ-007 ld_addr  input  AW  memory write address.
REQ-008 ld_data  input  WIDTH  memory write data.
REQ-009 ld_ready  output  1  write accepted this cycle when high with ld_valid.
REQ-010 start  input  1  run request, sampled in IDLE only.
REQ-011 mode  input  1  0 = one-shot, 1 = loop; latched at start.
REQ-012 num_vec  input  AW+1  vectors per pass, 1..DEPTH; latched at start.
REQ-013 stop  input  1  abort request.
REQ-014 vec_out  output  WIDTH  applied stimulus vector.
REQ-015 vec_valid  output  1  vec_out carries a new vector this cycle.
REQ-016 resp_in  input  WIDTH  DUT response, compressed into signature.
REQ-017 busy  output  1  high in RUN.
REQ-018 done  output  1  one-cycle pulse at end of run.
REQ-019 pass_cnt  output  16  completed passes in current/last run.
REQ-020 sig_out  output  WIDTH  MISR signature.

Function
REQ-021 States: IDLE, RUN, DONE; only IDLE accepts loads and start.
REQ-022 ld_ready = 1 in IDLE, 0 otherwise; write mem[ld_addr] <= ld_data when ld_valid && ld_ready; ld_addr >= DEPTH ignored.
REQ-023 IDLE->RUN on start with 1 <= num_vec <= DEPTH; start with num_vec 0 or > DEPTH ignored, state stays IDLE.
REQ-024 On accepted start: idx <= 0, pass_cnt <= 0, sig_out <= 0, mode/num_vec latched.
REQ-025 In RUN each cycle: vec_out <= mem[idx], vec_valid <= 1, idx advances by 1; first vector appears on vec_out the cycle after the start-accept cycle (latency 1).
REQ-026 When idx = num_vec-1 is issued: pass_cnt increments by 1 (saturates at 16'hFFFF); idx wraps to 0.
REQ-027 One-shot: after issuing idx = num_vec-1, RUN->DONE; loop: remain in RUN with no gap cycle.
REQ-028 stop in RUN: no vector issued that cycle or later, next state DONE; pass_cnt not incremented for partial pass; stop outside RUN ignored.
REQ-029 stop and last-vector issue in same cycle: stop wins for issue; since last vector not issued, pass not counted.
REQ-030 DONE lasts exactly one cycle with done = 1, then IDLE; start during DONE ignored.
REQ-031 vec_out holds last issued vector whenever vec_valid = 0.
REQ-032 MISR: on each cycle with vec_valid = 1, sig_out <= ({sig_out[WIDTH-2:0],1'b0} ^ (sig_out[WIDTH-1] ? POLY : 0)) ^ resp_in; otherwise holds.
REQ-033 sig_out, pass_cnt hold after done until next accepted start or reset.
REQ-034 busy = 1 exactly in RUN; vec_valid = 1 exactly on cycles following a RUN-issue cycle.

Reset
REQ-035 rst forces IDLE, vec_out = 0, vec_valid = 0, busy = 0, done = 0, pass_cnt = 0, sig_out = 0, idx = 0, ld_ready = 1 next cycle.
REQ-036 rst has priority over start, stop, ld_valid; rst mid-RUN aborts with no done pulse.
REQ-037 Memory contents not cleared by rst.

Verification
REQ-038 Load mem[0..3] = 1,2,3,4; start, mode 0, num_vec 4 -> vec_out 1,2,3,4 on 4 consecutive vec_valid cycles starting 1 cycle after start; done 1 cycle after last; pass_cnt = 1.
REQ-039 Same memory, mode 1, num_vec 3, stop after 7 issues -> sequence 1,2,3,1,2,3,1; pass_cnt = 2; done once; no 8th vec_valid.
REQ-040 resp_in = 0 all cycles, one-shot 4 vectors -> sig_out = 0; resp_in = 1 single cycle then 0, POLY default, WIDTH 62 -> sig_out = 1<<(remaining valid cycles).
REQ-041 start with num_vec 0 and DEPTH+1 -> no busy, no vec_valid, no done.
REQ-042 ld_valid during RUN -> ld_ready 0, memory unchanged (verified by second run).
REQ-043 rst asserted on 2nd RUN cycle -> next cycle all outputs at reset values, no done; subsequent start replays stored vectors correctly.
